// File: rtl/des_key_sched_if.sv
// Handshake bundle between a DES key-schedule requester and the subkey generator.
// The requester drives start/key/mode and accepts subkeys; the generator answers.
interface des_key_sched_if;
   logic        start;
   logic [63:0] key_in;
   logic        decrypt;
   logic [47:0] subkey;
   logic        subkey_valid;
   logic        subkey_ready;
   logic [3:0]  round;
   logic        busy;
   logic        done;

   modport master (
      output start, key_in, decrypt, subkey_ready,
      input  subkey, subkey_valid, round, busy, done
   );

   modport slave (
      input  start, key_in, decrypt, subkey_ready,
      output subkey, subkey_valid, round, busy, done
   );
endinterface

// File: rtl/des_key_sched.sv
// DES key schedule: streams the 16 round subkeys (forward or reverse order)
// over a valid/ready handshake, one subkey per cycle when not backpressured.
module des_key_sched (
   input logic            clk,
   input logic            n_rst,
   des_key_sched_if.slave bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_GEN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // FIPS 46-3 bit positions (1-based, MSB first)
   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };

   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };

   // Single-step advances happen leaving rounds 0, 7 and 14 in both directions.
   localparam logic [15:0] ONE_SHIFT_MASK = 16'h4081;

   logic [1:0]  r_state;
   logic [27:0] r_c;
   logic [27:0] r_d;
   logic [3:0]  r_round;
   logic        r_decrypt;

   logic [55:0] w_pc1;
   logic [27:0] w_c0;
   logic [27:0] w_d0;
   logic [55:0] w_cd;
   logic [47:0] w_pc2;
   logic [27:0] w_c_next;
   logic [27:0] w_d_next;
   logic        w_single;
   logic        w_gen;

   genvar gi;

   generate
      for (gi = 0; gi < 56; gi++) begin : g_pc1
         assign w_pc1[55-gi] = bus.key_in[64-PC1[gi]];
      end
   endgenerate

   assign w_c0 = w_pc1[55:28];
   assign w_d0 = w_pc1[27:0];
   assign w_cd = {r_c, r_d};

   generate
      for (gi = 0; gi < 48; gi++) begin : g_pc2
         assign w_pc2[47-gi] = w_cd[56-PC2[gi]];
      end
   endgenerate

   assign w_single = ONE_SHIFT_MASK[r_round];

   always_comb begin
      w_c_next = r_c;
      w_d_next = r_d;
      case ({r_decrypt, w_single})
         2'b01: begin
            w_c_next = {r_c[26:0], r_c[27]};
            w_d_next = {r_d[26:0], r_d[27]};
         end
         2'b00: begin
            w_c_next = {r_c[25:0], r_c[27:26]};
            w_d_next = {r_d[25:0], r_d[27:26]};
         end
         2'b11: begin
            w_c_next = {r_c[0], r_c[27:1]};
            w_d_next = {r_d[0], r_d[27:1]};
         end
         default: begin
            w_c_next = {r_c[1:0], r_c[27:2]};
            w_d_next = {r_d[1:0], r_d[27:2]};
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state   <= ST_IDLE;
         r_c       <= '0;
         r_d       <= '0;
         r_round   <= '0;
         r_decrypt <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.start) begin
                  r_decrypt <= bus.decrypt;
                  r_round   <= '0;
                  r_state   <= ST_GEN;
                  // Decryption starts at K16, whose C/D equals C0/D0.
                  if (bus.decrypt) begin
                     r_c <= w_c0;
                     r_d <= w_d0;
                  end else begin
                     r_c <= {w_c0[26:0], w_c0[27]};
                     r_d <= {w_d0[26:0], w_d0[27]};
                  end
               end
            end
            ST_GEN: begin
               if (bus.subkey_ready) begin
                  if (r_round == 4'd15) begin
                     r_round <= '0;
                     r_state <= ST_DONE;
                  end else begin
                     r_round <= r_round + 4'd1;
                     r_c     <= w_c_next;
                     r_d     <= w_d_next;
                  end
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_gen            = (r_state == ST_GEN);
   assign bus.subkey_valid = w_gen;
   assign bus.busy         = w_gen;
   assign bus.done         = (r_state == ST_DONE);
   assign bus.round        = w_gen ? r_round : 4'd0;
   assign bus.subkey       = w_gen ? w_pc2 : 48'h0;

endmodule

// File: tb/tb_des_key_sched.sv
// Randomised bench for des_key_sched: a closed-form key-schedule model
// (cumulative rotation from C0/D0) is compared against the DUT every cycle.
module tb_des_key_sched;

   localparam logic [63:0] KEX = 64'h133457799BBCDFF1;

   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic clk = 1'b0;
   logic n_rst;
   int   n_vec = 0;
   int   n_bad = 0;

   des_key_sched_if bus ();

   des_key_sched dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Subkey at sequence position idx, computed directly from the key.
   function automatic logic [47:0] key_sub(input logic [63:0] key, input logic dec, input int idx);
      logic [27:0] c;
      logic [27:0] d;
      logic [55:0] cd;
      logic [47:0] k;
      int n;
      int sh;
      for (int i = 0; i < 28; i++) begin
         c[27-i] = key[64-PC1[i]];
         d[27-i] = key[64-PC1[i+28]];
      end
      n  = dec ? 16 - idx : idx + 1;
      sh = 0;
      for (int i = 0; i < n; i++) sh += SHIFTS[i];
      sh = sh % 28;
      for (int i = 0; i < sh; i++) begin
         c = {c[26:0], c[27]};
         d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2[i]];
      return k;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: which run is active and which subkey is due.
   bit          m_active = 1'b0;
   bit          m_done   = 1'b0;
   int          m_idx    = 0;
   logic [63:0] m_key    = '0;
   bit          m_dec    = 1'b0;

   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         m_active <= 1'b0;
         m_done   <= 1'b0;
         m_idx    <= 0;
      end else if (m_active) begin
         if (bus.subkey_ready) begin
            if (m_idx == 15) begin
               m_active <= 1'b0;
               m_done   <= 1'b1;
               m_idx    <= 0;
            end else begin
               m_idx <= m_idx + 1;
            end
         end
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (bus.start) begin
         m_active <= 1'b1;
         m_idx    <= 0;
         m_key    <= bus.key_in;
         m_dec    <= bus.decrypt;
      end
   end

   always @(negedge clk) begin
      chk("valid",  {63'd0, bus.subkey_valid}, {63'd0, m_active});
      chk("busy",   {63'd0, bus.busy},         {63'd0, m_active});
      chk("done",   {63'd0, bus.done},         {63'd0, m_done});
      chk("round",  {60'd0, bus.round},        m_active ? 64'(m_idx) : 64'd0);
      chk("subkey", {16'd0, bus.subkey},       m_active ? {16'd0, key_sub(m_key, m_dec, m_idx)} : 64'd0);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_subkey"}, {16'd0, bus.subkey}, 64'd0);
      chk({tag, "_valid"},  {63'd0, bus.subkey_valid}, 64'd0);
      chk({tag, "_round"},  {60'd0, bus.round}, 64'd0);
      chk({tag, "_busy"},   {63'd0, bus.busy}, 64'd0);
      chk({tag, "_done"},   {63'd0, bus.done}, 64'd0);
   endtask

   // mode: 0 ready=1, 1 stall 3 at round 5, 2 random ready,
   //       3 start glitch at round 7, 4 reset at round 9, 5 start during DONE
   task automatic run(input logic [63:0] key, input logic dec, input int mode,
                      input logic lit, input logic [47:0] lit_first, input logic [47:0] lit_last);
      int          cyc;
      int          stalls;
      bit          got_first;
      bit          finished;
      bit          aborted;
      logic [47:0] first;
      logic [47:0] last;
      bus.key_in       = key;
      bus.decrypt      = dec;
      bus.start        = 1'b1;
      bus.subkey_ready = 1'b1;
      tick();
      bus.start   = 1'b0;
      bus.key_in  = {$urandom, $urandom};
      bus.decrypt = 1'($urandom_range(0, 1));
      cyc = 0; stalls = 0; got_first = 0; finished = 0; aborted = 0;
      first = '0; last = '0;
      while (!finished && !aborted && cyc < 200) begin
         if (bus.done) begin
            finished = 1;
         end else begin
            if (bus.subkey_valid) begin
               if (!got_first) first = bus.subkey;
               got_first = 1;
               last = bus.subkey;
            end
            bus.start        = 1'b0;
            bus.subkey_ready = 1'b1;
            if (mode == 1 && bus.subkey_valid && bus.round == 4'd5 && stalls < 3) begin
               bus.subkey_ready = 1'b0;
               stalls++;
            end
            if (mode == 2) bus.subkey_ready = ($urandom_range(0, 3) != 0);
            if (mode == 3 && bus.subkey_valid && bus.round == 4'd7 && stalls == 0) begin
               bus.start   = 1'b1;
               bus.key_in  = ~key;
               bus.decrypt = ~dec;
               stalls      = 1;
            end
            if (mode == 4 && bus.round == 4'd9) begin
               n_rst = 1'b0;
               #1;
               check_zero("rst_mid");
               #1;
               n_rst   = 1'b1;
               aborted = 1;
            end else begin
               tick();
               cyc++;
            end
         end
      end
      if (mode != 4 && !finished) begin
         n_bad++;
         $display("FAIL done_timeout: got no done after %0d cycles, required done", cyc);
      end
      if (finished && (mode == 0 || mode == 1 || mode == 3 || mode == 5))
         chk("cycles_to_done", 64'(cyc), (mode == 1) ? 64'd19 : 64'd16);
      if (lit) begin
         chk("first_subkey", {16'd0, first}, {16'd0, lit_first});
         chk("last_subkey",  {16'd0, last},  {16'd0, lit_last});
      end
      $display("run key=%h dec=%0d mode=%0d cycles=%0d first=%h last=%h", key, dec, mode, cyc, first, last);
      bus.start        = 1'b0;
      bus.subkey_ready = 1'b1;
      if (finished) begin
         if (mode == 5) bus.start = 1'b1;
         tick();
         bus.start = 1'b0;
         if (mode == 5) chk("start_in_done_ignored", {63'd0, bus.subkey_valid}, 64'd0);
      end
   endtask

   initial begin
      n_rst            = 1'b0;
      bus.start        = 1'($urandom_range(0, 1));
      bus.key_in       = {$urandom, $urandom};
      bus.decrypt      = 1'($urandom_range(0, 1));
      bus.subkey_ready = 1'($urandom_range(0, 1));
      #3;
      check_zero("rst_init");

      chk("pin_enc_k1",  {16'd0, key_sub(KEX, 1'b0, 0)},  64'h1B02EFFC7072);
      chk("pin_enc_k2",  {16'd0, key_sub(KEX, 1'b0, 1)},  64'h79AED9DBC9E5);
      chk("pin_enc_k16", {16'd0, key_sub(KEX, 1'b0, 15)}, 64'hCB3D8B0E17F5);
      chk("pin_dec_k16", {16'd0, key_sub(KEX, 1'b1, 0)},  64'hCB3D8B0E17F5);
      chk("pin_dec_k15", {16'd0, key_sub(KEX, 1'b1, 1)},  {16'd0, key_sub(KEX, 1'b0, 14)});

      bus.start        = 1'b0;
      bus.subkey_ready = 1'b1;
      @(negedge clk);
      n_rst = 1'b1;

      run(KEX, 1'b0, 0, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5);
      run(KEX, 1'b1, 0, 1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072);
      run(KEX, 1'b0, 1, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5);
      run(KEX, 1'b0, 3, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5);
      run(KEX, 1'b0, 4, 1'b0, 48'h0, 48'h0);
      run(KEX, 1'b0, 5, 1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5);
      for (int i = 0; i < 12; i++)
         run({$urandom, $urandom}, 1'($urandom_range(0, 1)), (i % 3 == 0) ? 2 : i % 6, 1'b0, 48'h0, 48'h0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
